// File: rtl/axis_header_extract.sv
// rtl/axis_header_extract.sv - strips a 1..DATA_BYTE_WD byte header off the first beat
// of each packet and realigns the remaining payload to the MSB lane.
module axis_header_extract #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   input  logic [DATA_WD-1:0]      s_data,
   input  logic [DATA_BYTE_WD-1:0] s_keep,
   input  logic                    s_last,
   output logic                    s_ready,
   input  logic [BYTE_CNT_WD:0]    cfg_hdr_bytes,
   output logic                    m_valid,
   output logic [DATA_WD-1:0]      m_data,
   output logic [DATA_BYTE_WD-1:0] m_keep,
   output logic                    m_last,
   input  logic                    m_ready,
   output logic                    h_valid,
   output logic [DATA_WD-1:0]      h_data,
   output logic [DATA_BYTE_WD-1:0] h_keep,
   input  logic                    h_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   localparam logic [BYTE_CNT_WD:0] DBW_C = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);

   state_t                  state_q, state_d;
   logic [BYTE_CNT_WD:0]    s_q, s_d;
   logic [DATA_WD-1:0]      resid_q, resid_d;
   logic [DATA_BYTE_WD-1:0] resid_keep_q, resid_keep_d;
   logic                    m_valid_q, m_valid_d;
   logic [DATA_WD-1:0]      m_data_q, m_data_d;
   logic [DATA_BYTE_WD-1:0] m_keep_q, m_keep_d;
   logic                    m_last_q, m_last_d;
   logic                    h_valid_q, h_valid_d;
   logic [DATA_WD-1:0]      h_data_q, h_data_d;
   logic [DATA_BYTE_WD-1:0] h_keep_q, h_keep_d;

   logic [BYTE_CNT_WD:0]    s_cfg, s_cur, rem_cur;
   logic [BYTE_CNT_WD+3:0]  sh_s, sh_rem;
   logic [DATA_WD-1:0]      in_tail, in_head;
   logic [DATA_BYTE_WD-1:0] in_tail_keep, in_head_keep, hdr_keep, new_m_keep;
   logic                    rdy, accept, m_free, tail_left;

   function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] keep);
      logic [DATA_WD-1:0] mask;
      mask = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         mask[8*i +: 8] = {8{keep[i]}};
      end
      return mask;
   endfunction

   // The header length is taken from cfg only on the first beat; later beats use the latched copy.
   always_comb begin
      s_cfg = cfg_hdr_bytes;
      if (cfg_hdr_bytes == '0) begin
         s_cfg = (BYTE_CNT_WD+1)'(1);
      end else if (cfg_hdr_bytes > DBW_C) begin
         s_cfg = DBW_C;
      end
      s_cur        = (state_q == IDLE) ? s_cfg : s_q;
      rem_cur      = DBW_C - s_cur;
      sh_s         = {s_cur, 3'b000};
      sh_rem       = {rem_cur, 3'b000};
      in_tail      = s_data << sh_s;
      in_tail_keep = s_keep << s_cur;
      in_head      = s_data >> sh_rem;
      in_head_keep = s_keep >> rem_cur;
      hdr_keep     = ~({DATA_BYTE_WD{1'b1}} >> s_cur) & s_keep;
      new_m_keep   = resid_keep_q | in_head_keep;
      tail_left    = (in_tail_keep != '0);
      m_free       = !m_valid_q || m_ready;
   end

   always_comb begin
      rdy = 1'b0;
      case (state_q)
         IDLE:    rdy = !h_valid_q || h_ready;
         STREAM:  rdy = m_free;
         default: rdy = 1'b0;
      endcase
      s_ready = rst_n & rdy;
      accept  = s_valid && s_ready;
   end

   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      resid_d      = resid_q;
      resid_keep_d = resid_keep_q;
      m_valid_d    = m_valid_q;
      m_data_d     = m_data_q;
      m_keep_d     = m_keep_q;
      m_last_d     = m_last_q;
      h_valid_d    = h_valid_q;
      h_data_d     = h_data_q;
      h_keep_d     = h_keep_q;

      if (m_valid_q && m_ready) m_valid_d = 1'b0;
      if (h_valid_q && h_ready) h_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               h_valid_d    = 1'b1;
               h_keep_d     = hdr_keep;
               h_data_d     = s_data & lane_mask(hdr_keep);
               s_d          = s_cfg;
               resid_d      = in_tail;
               resid_keep_d = in_tail_keep;
               if (!s_last) begin
                  state_d = STREAM;
               end else if (tail_left) begin
                  state_d = FLUSH;
               end
            end
         end
         STREAM: begin
            if (accept) begin
               m_valid_d    = 1'b1;
               m_keep_d     = new_m_keep;
               m_data_d     = (resid_q | in_head) & lane_mask(new_m_keep);
               m_last_d     = 1'b0;
               resid_d      = in_tail;
               resid_keep_d = in_tail_keep;
               if (s_last) begin
                  // Bytes beyond the header width spill into one extra flush beat.
                  if (tail_left) begin
                     state_d = FLUSH;
                  end else begin
                     m_last_d = 1'b1;
                     state_d  = IDLE;
                  end
               end
            end
         end
         FLUSH: begin
            if (m_free) begin
               m_valid_d    = 1'b1;
               m_keep_d     = resid_keep_q;
               m_data_d     = resid_q & lane_mask(resid_keep_q);
               m_last_d     = 1'b1;
               resid_d      = '0;
               resid_keep_d = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         s_q          <= (BYTE_CNT_WD+1)'(1);
         resid_q      <= '0;
         resid_keep_q <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_keep_q     <= '0;
         m_last_q     <= 1'b0;
         h_valid_q    <= 1'b0;
         h_data_q     <= '0;
         h_keep_q     <= '0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         resid_q      <= resid_d;
         resid_keep_q <= resid_keep_d;
         m_valid_q    <= m_valid_d;
         m_data_q     <= m_data_d;
         m_keep_q     <= m_keep_d;
         m_last_q     <= m_last_d;
         h_valid_q    <= h_valid_d;
         h_data_q     <= h_data_d;
         h_keep_q     <= h_keep_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_keep  = m_keep_q;
   assign m_last  = m_last_q;
   assign h_valid = h_valid_q;
   assign h_data  = h_data_q;
   assign h_keep  = h_keep_q;

endmodule
